// File: rtl/ln_pkg.sv
// Fixed-point types and constants shared by the LayerNorm datapath
// (layernorm_stats, pwl_approx).
package ln_pkg;
    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 11;
    localparam int SQ_FRAC_W = 22;

    typedef logic signed [DATA_W-1:0] s_q4_11_t;
    typedef logic        [DATA_W-1:0] u_q5_11_t;

    localparam u_q5_11_t VAR_MAX = 16'hFFFF;
endpackage

// File: rtl/layernorm_stats_if.sv
// Element stream in, statistics out for layernorm_stats.
interface layernorm_stats_if;
    import ln_pkg::*;

    logic     i_valid;
    s_q4_11_t i_data;
    logic     o_valid;
    s_q4_11_t o_mean;
    u_q5_11_t o_variance;
    logic     o_sat;

    modport master (output i_valid, i_data, input o_valid, o_mean, o_variance, o_sat);
    modport slave  (input i_valid, i_data, output o_valid, o_mean, o_variance, o_sat);
endinterface

// File: rtl/ln_stats_final.sv
// Stages B-D: mean/E[x^2], mean^2, subtract and clamp/saturate to UQ5.11.
// LN_STATS_EPS_EN adds EPS_Q22 to the difference before clamping.
module ln_stats_final
    import ln_pkg::*;
#(
    parameter int N_LOG2  = 6,
    parameter int EPS_Q22 = 42,
    parameter int SUM_W   = DATA_W + N_LOG2,
    parameter int SQ_W    = 2*DATA_W + N_LOG2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_vld,
    input  logic signed [SUM_W-1:0] i_sum,
    input  logic        [SQ_W-1:0]  i_sumsq,
    output logic                    o_valid,
    output s_q4_11_t                o_mean,
    output u_q5_11_t                o_variance,
    output logic                    o_sat
);
    localparam int STAGES = 4;

`ifdef LN_STATS_EPS_EN
    localparam logic signed [32:0] EPS_TERM = 33'(EPS_Q22);
`endif

    logic [STAGES-1:0]  vld_pipe_d, vld_pipe_q;
    s_q4_11_t           mean_b_d, mean_b_q, mean_c_d, mean_c_q, mean_d_d, mean_d_q;
    logic [31:0]        ex2_b_d, ex2_b_q, ex2_c_d, ex2_c_q, msq_c_d, msq_c_q;
    logic signed [32:0] d_d, d_q;
    s_q4_11_t           mean_o_d, mean_o_q;
    u_q5_11_t           var_o_d, var_o_q;
    logic               sat_o_d, sat_o_q;
    logic [SQ_W-1:0]    ex2_full;
    logic signed [31:0] msq_full;
    logic signed [32:0] diff;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        mean_b_d   = mean_b_q;
        ex2_b_d    = ex2_b_q;
        mean_c_d   = mean_c_q;
        ex2_c_d    = ex2_c_q;
        msq_c_d    = msq_c_q;
        mean_d_d   = mean_d_q;
        d_d        = d_q;
        mean_o_d   = mean_o_q;
        var_o_d    = var_o_q;
        sat_o_d    = sat_o_q;
        ex2_full   = i_sumsq >> N_LOG2;
        msq_full   = mean_b_q * mean_b_q;
`ifdef LN_STATS_EPS_EN
        diff = $signed({1'b0, ex2_c_q}) - $signed({1'b0, msq_c_q}) + EPS_TERM;
`else
        diff = $signed({1'b0, ex2_c_q}) - $signed({1'b0, msq_c_q});
`endif
        if (i_en) begin
            vld_pipe_d = {vld_pipe_q[STAGES-2:0], i_vld};
            if (i_vld) begin
                // Slice == (sum >>> N_LOG2) truncated to 16 bits (floor division).
                mean_b_d = i_sum[N_LOG2 +: DATA_W];
                ex2_b_d  = 32'(ex2_full);
            end
            if (vld_pipe_q[0]) begin
                mean_c_d = mean_b_q;
                ex2_c_d  = ex2_b_q;
                msq_c_d  = unsigned'(msq_full);
            end
            if (vld_pipe_q[1]) begin
                mean_d_d = mean_c_q;
                d_d      = diff;
            end
            if (vld_pipe_q[2]) begin
                mean_o_d = mean_d_q;
                if (d_q[32]) begin
                    var_o_d = '0;
                    sat_o_d = 1'b0;
                end else if (|d_q[31:27]) begin
                    var_o_d = VAR_MAX;
                    sat_o_d = 1'b1;
                end else begin
                    var_o_d = d_q[26:11];
                    sat_o_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe_q <= '0;
            mean_b_q   <= '0;
            ex2_b_q    <= '0;
            mean_c_q   <= '0;
            ex2_c_q    <= '0;
            msq_c_q    <= '0;
            mean_d_q   <= '0;
            d_q        <= '0;
            mean_o_q   <= '0;
            var_o_q    <= '0;
            sat_o_q    <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            mean_b_q   <= mean_b_d;
            ex2_b_q    <= ex2_b_d;
            mean_c_q   <= mean_c_d;
            ex2_c_q    <= ex2_c_d;
            msq_c_q    <= msq_c_d;
            mean_d_q   <= mean_d_d;
            d_q        <= d_d;
            mean_o_q   <= mean_o_d;
            var_o_q    <= var_o_d;
            sat_o_q    <= sat_o_d;
        end
    end

    assign o_valid    = vld_pipe_q[STAGES-1];
    assign o_mean     = mean_o_q;
    assign o_variance = var_o_q;
    assign o_sat      = sat_o_q;
endmodule

// File: rtl/layernorm_stats.sv
// Per-token sum / sum-of-squares accumulator feeding ln_stats_final.
// Optional epsilon term (in ln_stats_final) enabled by LN_STATS_EPS_EN.
module layernorm_stats
    import ln_pkg::*;
#(
    parameter int N_LOG2  = 6,
    parameter int EPS_Q22 = 42
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    layernorm_stats_if.slave  bus
);
    localparam int SUM_W = DATA_W + N_LOG2;
    localparam int SQ_W  = 2*DATA_W + N_LOG2;
    localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};

    logic [N_LOG2-1:0]         cnt_d, cnt_q;
    logic signed [SUM_W-1:0]   sum_d, sum_q, snap_sum_d, snap_sum_q;
    logic        [SQ_W-1:0]    sumsq_d, sumsq_q, snap_sumsq_d, snap_sumsq_q;
    logic                      vld_a_d, vld_a_q;
    logic signed [SUM_W-1:0]   x_ext;
    logic signed [2*DATA_W-1:0] x_sq;
    logic        [SQ_W-1:0]    sq_ext;

    always_comb begin
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        sumsq_d      = sumsq_q;
        snap_sum_d   = snap_sum_q;
        snap_sumsq_d = snap_sumsq_q;
        vld_a_d      = vld_a_q;
        x_ext        = SUM_W'(bus.i_data);
        x_sq         = bus.i_data * bus.i_data;
        sq_ext       = SQ_W'(unsigned'(x_sq));
        if (i_en) begin
            vld_a_d = 1'b0;
            if (bus.i_valid) begin
                cnt_d = cnt_q + N_LOG2'(1);
                // Last element goes straight to the snapshot so the next vector can start next cycle.
                if (cnt_q == CNT_LAST) begin
                    snap_sum_d   = sum_q + x_ext;
                    snap_sumsq_d = sumsq_q + sq_ext;
                    sum_d        = '0;
                    sumsq_d      = '0;
                    vld_a_d      = 1'b1;
                end else begin
                    sum_d   = sum_q + x_ext;
                    sumsq_d = sumsq_q + sq_ext;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            sum_q        <= '0;
            sumsq_q      <= '0;
            snap_sum_q   <= '0;
            snap_sumsq_q <= '0;
            vld_a_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            sumsq_q      <= sumsq_d;
            snap_sum_q   <= snap_sum_d;
            snap_sumsq_q <= snap_sumsq_d;
            vld_a_q      <= vld_a_d;
        end
    end

    ln_stats_final #(
        .N_LOG2  (N_LOG2),
        .EPS_Q22 (EPS_Q22),
        .SUM_W   (SUM_W),
        .SQ_W    (SQ_W)
    ) u_final (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .i_vld      (vld_a_q),
        .i_sum      (snap_sum_q),
        .i_sumsq    (snap_sumsq_q),
        .o_valid    (bus.o_valid),
        .o_mean     (bus.o_mean),
        .o_variance (bus.o_variance),
        .o_sat      (bus.o_sat)
    );
endmodule
